// File: rtl/pp_entry_fwd_multi_pkg.sv
// pp_entry_fwd_multi: shared types and constants.
// FSM encoding, channel limit and perf counter width.
package pp_entry_fwd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int MAX_CH = 16;
    localparam int PERF_W = 32;

    function automatic logic [PERF_W-1:0] sat_inc(
        input logic [PERF_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pp_entry_fwd_multi_if.sv
// pp_entry_fwd_multi: ap_ctrl_chain control plus FIFO bus bundle.
// master = controller/FIFO side, slave = forwarding block.
interface pp_entry_fwd_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    logic                     ap_start;
    logic                     ap_continue;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     ap_ready;
    logic                     blk_n;
    logic [NUM_CH*DATA_W-1:0] in_dout;
    logic [NUM_CH-1:0]        in_empty_n;
    logic [NUM_CH-1:0]        in_read;
    logic [NUM_CH*DATA_W-1:0] out_din;
    logic [NUM_CH-1:0]        out_full_n;
    logic [NUM_CH-1:0]        out_write;

    modport master (
        output ap_start, ap_continue,
        output in_dout, in_empty_n, out_full_n,
        input  ap_done, ap_idle, ap_ready, blk_n,
        input  in_read, out_din, out_write
    );

    modport slave (
        input  ap_start, ap_continue,
        input  in_dout, in_empty_n, out_full_n,
        output ap_done, ap_idle, ap_ready, blk_n,
        output in_read, out_din, out_write
    );
endinterface

// File: rtl/pp_entry_fwd_multi_chan.sv
// pp_entry_fwd_multi: one forwarded channel.
// Holds the popped word until its own output FIFO accepts it.
module pp_entry_fwd_chan #(
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clr,
    input  logic              collect,
    input  logic              emit,
    input  logic [DATA_W-1:0] din,
    input  logic              empty_n,
    input  logic              full_n,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] dout,
    output logic              got,
    output logic              sent,
    output logic              stall
);
    logic [DATA_W-1:0] hold;

    assign rd    = collect & ~got & empty_n;
    assign wr    = emit & ~sent & full_n;
    assign stall = (collect & ~got & ~empty_n)
                 | (emit & ~sent & ~full_n);
    assign dout  = hold;

    // Capture one word per transaction and remember what was sent.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            got  <= 1'b0;
            sent <= 1'b0;
            hold <= '0;
        end else if (clr) begin
            got  <= 1'b0;
            sent <= 1'b0;
        end else begin
            if (rd) begin
                got  <= 1'b1;
                hold <= din;
            end
            if (wr) begin
                sent <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/pp_entry_fwd_multi.sv
// pp_entry_fwd_multi: per-channel decoupled scalar forwarder.
// Optional PP_ENTRY_FWD_PERF_CNT_EN adds txn_cnt / stall_cnt.
module pp_entry_fwd_multi
    import pp_entry_fwd_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    pp_entry_fwd_multi_if.slave bus
`ifdef PP_ENTRY_FWD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  txn_cnt,
    output logic [PERF_W-1:0]  stall_cnt
`endif
);
    state_t            state;
    logic [NUM_CH-1:0] got;
    logic [NUM_CH-1:0] sent;
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] stall;
    logic              clr;
    logic              collect;
    logic              emit;
    logic              got_all;
    logic              sent_all;
    logic              blk_n;

    assign collect  = (state == COLLECT);
    assign emit     = (state == EMIT);
    assign clr      = (state == IDLE) & bus.ap_start;
    assign got_all  = &(got | rd);
    assign sent_all = &(sent | wr);
    assign blk_n    = ~|stall;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pp_entry_fwd_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .clr      (clr),
            .collect  (collect),
            .emit     (emit),
            .din      (bus.in_dout[g*DATA_W +: DATA_W]),
            .empty_n  (bus.in_empty_n[g]),
            .full_n   (bus.out_full_n[g]),
            .rd       (rd[g]),
            .wr       (wr[g]),
            .dout     (bus.out_din[g*DATA_W +: DATA_W]),
            .got      (got[g]),
            .sent     (sent[g]),
            .stall    (stall[g])
        );
    end

    assign bus.in_read   = rd;
    assign bus.out_write = wr;
    assign bus.ap_ready  = collect & got_all;
    assign bus.ap_done   = (state == DONE);
    assign bus.ap_idle   = (state == IDLE);
    assign bus.blk_n     = blk_n;

    // Transaction sequencing: collect all, emit all, hold done.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.ap_start)    state <= COLLECT;
                COLLECT: if (got_all)         state <= EMIT;
                EMIT:    if (sent_all)        state <= DONE;
                DONE:    if (bus.ap_continue) state <= IDLE;
                default:                      state <= IDLE;
            endcase
        end
    end

`ifdef PP_ENTRY_FWD_PERF_CNT_EN
    // Saturating counts of completed transactions and stall cycles.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            txn_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == DONE && bus.ap_continue) begin
                txn_cnt <= sat_inc(txn_cnt);
            end
            if (!blk_n) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
`endif
endmodule
